// File: rtl/autotune_pkg.sv
// autotune_pkg: shared types and helpers for the autotune pitch-correction path
package autotune_pkg;
  typedef enum logic [1:0] {
    NEAREST = 2'd0,
    FLOOR   = 2'd1,
    CEIL    = 2'd2
  } snap_mode_t;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE    = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    DECIDE   = 3'd4,
    HOLD     = 3'd5
  } snap_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, lowest requester at or above the pointer wins, with wrap
module rr_arbiter
  import autotune_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IW = idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx
);
  logic [IW-1:0] ptr;
  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_CH]) begin
        grant = '0;
        grant[(int'(ptr) + i) % NUM_CH] = 1'b1;
        grant_idx = IW'((int'(ptr) + i) % NUM_CH);
      end
  end
  always_ff @(posedge clk_in)
    if (!rst_n_in) ptr <= '0;
    else if (advance) ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// xilinx_single_port_ram_read_first: single-port read-first block RAM, optional output register
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 12,
  parameter int    RAM_DEPTH       = 64,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string INIT_FILE       = ""
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);
  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;
  always_ff @(posedge clka)
    if (ena) begin
      if (wea) ram[addra] <= dina;
      ram_data <= ram[addra];
    end
  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
    assign douta = ram_data;
  end else begin : g_high
    always_ff @(posedge clka)
      if (rsta) douta <= '0;
      else if (regcea) douta <= ram_data;
  end
  // Contents are attached from INIT_FILE by the implementation flow's memory initialisation.
  if (INIT_FILE != "") begin : g_init_file
  end
endmodule

// File: rtl/semitone_snapper.sv
// semitone_snapper: fixed-latency nearest/floor/ceil search over a sorted BRAM table
module semitone_snapper
  import autotune_pkg::*;
#(
  parameter int    WIDTH     = 12,
  parameter int    DEPTH     = 64,
  parameter int    NUM_CH    = 4,
  parameter int    RD_LAT    = 2,
  parameter string INIT_FILE = "semitones.mem",
  localparam int   CW        = idx_w(NUM_CH),
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_key,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [1:0]              mode_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           out_ch,
  output logic [AW-1:0]           out_index,
  output logic [WIDTH-1:0]        out_value,
  output logic signed [WIDTH:0]   out_err,
  output logic                    out_clamped
);
  snap_state_t      state;
  snap_mode_t       mode_q;
  logic [WIDTH-1:0] key_q, v_lo, v_hi, rd_data, pick_val;
  logic [AW-1:0]    lo, step, addr, lo_next, pick_idx;
  logic [CW-1:0]    ch_q, grant_idx;
  logic [NUM_CH-1:0] grant;
  logic [7:0]       pcnt;
  logic [3:0]       wcnt;
  logic [WIDTH:0]   d_lo, d_hi;
  logic             accept, rd_done, below, at_top, pick_hi, clamp;
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req(in_valid), .advance(accept),
    .grant(grant), .grant_idx(grant_idx)
  );
  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH(WIDTH), .RAM_DEPTH(DEPTH),
    .RAM_PERFORMANCE(RD_LAT > 1 ? "HIGH_PERFORMANCE" : "LOW_LATENCY"),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .addra(addr), .dina('0), .clka(clk_in), .wea(1'b0), .ena(1'b1),
    .rsta(1'b0), .regcea(1'b1), .douta(rd_data)
  );
  assign in_ready = (state == IDLE) ? grant : '0;
  assign accept   = |(in_valid & in_ready);
  assign rd_done  = wcnt == 4'(RD_LAT);
  assign lo_next  = (lo == AW'(DEPTH - 1)) ? lo : lo + 1'b1;
  // Address is held for the whole access; the RAM only needs it on the issue cycle.
  assign addr     = (state == PROBE) ? lo + step : (state == FETCH_HI) ? lo_next : lo;
  always_comb begin
    d_lo     = {1'b0, key_q} - {1'b0, v_lo};
    d_hi     = {1'b0, v_hi} - {1'b0, key_q};
    below    = key_q < v_lo;
    at_top   = (lo == AW'(DEPTH - 1)) || key_q >= v_hi;
    pick_hi  = !below && !at_top &&
               (mode_q == CEIL ? key_q != v_lo : mode_q == FLOOR ? 1'b0 : d_hi < d_lo);
    pick_idx = pick_hi ? lo + 1'b1 : lo;
    pick_val = pick_hi ? v_hi : v_lo;
    clamp    = below || (at_top && mode_q == CEIL && key_q > v_lo);
  end
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      state       <= IDLE;
      mode_q      <= NEAREST;
      key_q       <= '0;
      ch_q        <= '0;
      lo          <= '0;
      step        <= '0;
      pcnt        <= '0;
      wcnt        <= '0;
      v_lo        <= '0;
      v_hi        <= '0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_index   <= '0;
      out_value   <= '0;
      out_err     <= '0;
      out_clamped <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            key_q  <= in_key[grant_idx*WIDTH +: WIDTH];
            mode_q <= (mode_in == 2'd3) ? NEAREST : snap_mode_t'(mode_in);
            ch_q   <= grant_idx;
            lo     <= '0;
            step   <= AW'(DEPTH / 2);
            pcnt   <= '0;
            wcnt   <= '0;
            state  <= PROBE;
          end
        PROBE: begin
          wcnt <= rd_done ? '0 : wcnt + 1'b1;
          if (rd_done) begin
            if (rd_data <= key_q) lo <= lo + step;
            step <= step >> 1;
            pcnt <= pcnt + 1'b1;
            if (pcnt == 8'(AW - 1)) state <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          wcnt <= rd_done ? '0 : wcnt + 1'b1;
          if (rd_done) begin
            v_lo  <= rd_data;
            state <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          wcnt <= rd_done ? '0 : wcnt + 1'b1;
          if (rd_done) begin
            v_hi  <= rd_data;
            state <= DECIDE;
          end
        end
        DECIDE: begin
          out_valid   <= 1'b1;
          out_ch      <= ch_q;
          out_index   <= pick_idx;
          out_value   <= pick_val;
          out_err     <= $signed({1'b0, key_q} - {1'b0, pick_val});
          out_clamped <= clamp;
          state       <= HOLD;
        end
        HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_semitone_snapper.sv
// tb_semitone_snapper: directed checks of the semitone snapper on a 100+10k table
module tb_semitone_snapper;
  import autotune_pkg::*;
  localparam int W = 12;
  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic [3:0]         in_valid = '0;
  logic [4*W-1:0]     in_key = '0;
  logic [3:0]         in_ready;
  logic [1:0]         mode_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         out_ch;
  logic [5:0]         out_index;
  logic [W-1:0]       out_value;
  logic signed [W:0]  out_err;
  logic               out_clamped;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  semitone_snapper dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .in_valid(in_valid), .in_key(in_key),
    .in_ready(in_ready), .mode_in(mode_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_index(out_index), .out_value(out_value), .out_err(out_err),
    .out_clamped(out_clamped)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " out_ch"}, out_ch, 0);
    check({tag, " out_index"}, out_index, 0);
    check({tag, " out_value"}, out_value, 0);
    check({tag, " out_err"}, out_err, 0);
    check({tag, " out_clamped"}, out_clamped, 0);
    rst_n_in = 1'b1;
  endtask
  task automatic send(input int ch, input int key, input int mode);
    int n = 0;
    @(negedge clk_in);
    in_valid[ch] = 1'b1;
    in_key[ch*W +: W] = W'(key);
    mode_in = 2'(mode);
    #1;
    while (!in_ready[ch] && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check("grant", in_ready[ch], 1);
    acc_cyc = cyc + 1;
    @(posedge clk_in);
    #1 in_valid[ch] = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    @(negedge clk_in);
    while (!out_valid && n < 100) begin
      @(negedge clk_in);
      n++;
    end
  endtask
  task automatic result(input string tag, input int ch, input int idx, input int val,
                        input int err, input int clamped);
    wait_valid();
    check({tag, " valid"}, out_valid, 1);
    check({tag, " latency"}, cyc - acc_cyc, 25);
    check({tag, " ch"}, out_ch, ch);
    check({tag, " index"}, out_index, idx);
    check({tag, " value"}, out_value, val);
    check({tag, " err"}, out_err, err);
    check({tag, " clamped"}, out_clamped, clamped);
    out_ready = 1'b1;
    @(negedge clk_in);
    out_ready = 1'b0;
    check({tag, " release"}, out_valid, 0);
  endtask
  initial begin
    for (int k = 0; k < 64; k++) dut.u_ram.ram[k] = W'(100 + 10 * k);
    do_reset("reset");
    send(0, 155, NEAREST);
    result("tie155", 0, 5, 150, 5, 0);
    send(1, 157, NEAREST);
    result("near157", 1, 6, 160, -3, 0);
    send(1, 157, FLOOR);
    result("floor157", 1, 5, 150, 7, 0);
    send(1, 157, CEIL);
    result("ceil157", 1, 6, 160, -3, 0);
    send(1, 150, CEIL);
    result("ceil150", 1, 5, 150, 0, 0);
    send(2, 157, 3);
    result("rsvd157", 2, 6, 160, -3, 0);
    send(3, 40, NEAREST);
    result("low40", 3, 0, 100, -60, 1);
    send(0, 900, CEIL);
    result("high900", 0, 63, 730, 170, 1);
    send(0, 730, CEIL);
    result("top730", 0, 63, 730, 0, 0);
    do_reset("reset2");
    @(negedge clk_in);
    in_key = {12'd400, 12'd300, 12'd200, 12'd100};
    mode_in = 2'(NEAREST);
    in_valid = 4'hF;
    for (int r = 0; r < 4; r++) begin
      wait_valid();
      if (r == 3) in_valid = '0;
      check("rr ch", out_ch, r);
      check("rr index", out_index, 10 * r);
      check("rr value", out_value, 100 + 100 * r);
      out_ready = 1'b1;
      @(negedge clk_in);
      out_ready = 1'b0;
    end
    send(2, 300, CEIL);
    wait_valid();
    in_key[0 +: W] = W'(500);
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      check("stall valid", out_valid, 1);
      check("stall index", out_index, 20);
      check("stall value", out_value, 300);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk_in);
    check("stall release", out_valid, 0);
    check("post-hold grant", in_ready, 4'b0001);
    out_ready = 1'b0;
    in_valid = '0;
    send(1, 300, NEAREST);
    repeat (5) @(negedge clk_in);
    do_reset("midrst");
    @(negedge clk_in);
    in_key[1*W +: W] = W'(200);
    in_key[3*W +: W] = W'(400);
    in_valid = 4'b1010;
    #1;
    check("ptr restart", in_ready, 4'b0010);
    acc_cyc = cyc + 1;
    @(posedge clk_in);
    #1 in_valid = '0;
    result("after rst", 1, 10, 200, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
